// File: rtl/mips_data_mem_pkg.sv
// Shared address map, STATUS bit positions and MMIO decode helpers for the
// M-stage data memory responder.
package mips_data_mem_pkg;

    localparam logic [31:0] MMIO_BASE  = 32'h8000_0000;
    localparam logic [31:0] OFF_LED    = 32'h0000_0000;
    localparam logic [31:0] OFF_SW     = 32'h0000_0004;
    localparam logic [31:0] OFF_CYCLE  = 32'h0000_0008;
    localparam logic [31:0] OFF_CMP    = 32'h0000_000C;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0010;

    localparam int STATUS_TIMER_HIT = 0;
    localparam int STATUS_BUS_ERR   = 1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_LED,
        SEL_SW,
        SEL_CYCLE,
        SEL_CMP,
        SEL_STATUS
    } mmio_sel_e;

    // Exact-match decode, so misaligned MMIO addresses fall through to SEL_NONE.
    function automatic mmio_sel_e mmio_decode(input logic [31:0] addr);
        mmio_sel_e sel;
        sel = SEL_NONE;
        case (addr)
            MMIO_BASE + OFF_LED:    sel = SEL_LED;
            MMIO_BASE + OFF_SW:     sel = SEL_SW;
            MMIO_BASE + OFF_CYCLE:  sel = SEL_CYCLE;
            MMIO_BASE + OFF_CMP:    sel = SEL_CMP;
            MMIO_BASE + OFF_STATUS: sel = SEL_STATUS;
            default:                sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic mmio_writable(input mmio_sel_e sel);
        return (sel == SEL_LED) || (sel == SEL_CMP) || (sel == SEL_STATUS);
    endfunction

endpackage

// File: rtl/mips_mmio_regs.sv
// MMIO register block: LED, synchronised switches, free-running cycle counter,
// timer compare, sticky STATUS with write-1-to-clear, and the MMIO read mux.
module mips_mmio_regs
    import mips_data_mem_pkg::*;
#(
    parameter int LED_W = 16,
    parameter int SW_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  mmio_sel_e        sel_i,
    input  logic             we_i,
    input  logic [31:0]      wdata_i,
    input  logic             bus_err_set_i,
    input  logic [SW_W-1:0]  sw_i,
    output logic [31:0]      rdata_o,
    output logic [LED_W-1:0] led_o,
    output logic             irq_o
);

    logic [LED_W-1:0] led_q,      led_d;
    logic [SW_W-1:0]  sw_meta_q,  sw_meta_d;
    logic [SW_W-1:0]  sw_sync_q,  sw_sync_d;
    logic [31:0]      cycle_q,    cycle_d;
    logic [31:0]      cmp_q,      cmp_d;
    logic [1:0]       status_q,   status_d;

    always_comb begin
        led_d     = led_q;
        cmp_d     = cmp_q;
        status_d  = status_q;
        cycle_d   = cycle_q + 32'd1;
        sw_meta_d = sw_i;
        sw_sync_d = sw_meta_q;

        if (we_i && sel_i == SEL_LED)    led_d = wdata_i[LED_W-1:0];
        if (we_i && sel_i == SEL_CMP)    cmp_d = wdata_i;
        if (we_i && sel_i == SEL_STATUS) status_d = status_q & ~wdata_i[1:0];

        // Set terms come after the clear so a coincident set wins; the match
        // uses the pre-update compare value.
        if (cycle_q == cmp_q) status_d[STATUS_TIMER_HIT] = 1'b1;
        if (bus_err_set_i)    status_d[STATUS_BUS_ERR]   = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            cycle_q   <= '0;
            cmp_q     <= 32'hFFFF_FFFF;
            status_q  <= '0;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            cycle_q   <= cycle_d;
            cmp_q     <= cmp_d;
            status_q  <= status_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (sel_i)
            SEL_LED:    rdata_o = 32'(led_q);
            SEL_SW:     rdata_o = 32'(sw_sync_q);
            SEL_CYCLE:  rdata_o = cycle_q;
            SEL_CMP:    rdata_o = cmp_q;
            SEL_STATUS: rdata_o = {30'd0, status_q};
            default:    rdata_o = '0;
        endcase
    end

    assign led_o = led_q;
    assign irq_o = status_q[STATUS_TIMER_HIT];

endmodule

// File: rtl/mips_data_mem.sv
// M-stage data port responder: address decode, word RAM with synchronous write
// and combinational read, MMIO block, load-data mux and bus error detection.
module mips_data_mem
    import mips_data_mem_pkg::*;
#(
    parameter int RAM_AW = 8,
    parameter int LED_W  = 16,
    parameter int SW_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memwriteM,
    input  logic [31:0]      aluoutM,
    input  logic [31:0]      writedataM,
    output logic [31:0]      readdataM,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] led,
    output logic             irq
);

    localparam int RAM_DEPTH = 2 ** RAM_AW;

    logic              aligned;
    logic              ram_hit;
    logic [RAM_AW-1:0] ram_idx;
    mmio_sel_e         mmio_sel;
    logic [31:0]       mmio_rdata;
    logic              bus_err_set;
    logic [31:0]       ram_q [RAM_DEPTH];

    assign aligned  = (aluoutM[1:0] == 2'b00);
    assign ram_hit  = aligned && ((aluoutM >> (RAM_AW + 2)) == 32'd0);
    assign ram_idx  = aluoutM[RAM_AW+1:2];
    assign mmio_sel = mmio_decode(aluoutM);

    // Only stores can fault; aluoutM is live every cycle so reads must not.
    assign bus_err_set = memwriteM && !ram_hit && !mmio_writable(mmio_sel);

    // Contents are deliberately left unreset; reset only blocks the store.
    always_ff @(posedge clk) begin
        if (!rst && memwriteM && ram_hit) begin
            ram_q[ram_idx] <= writedataM;
        end
    end

    mips_mmio_regs #(
        .LED_W (LED_W),
        .SW_W  (SW_W)
    ) u_mmio (
        .clk_i         (clk),
        .rst_i         (rst),
        .sel_i         (mmio_sel),
        .we_i          (memwriteM),
        .wdata_i       (writedataM),
        .bus_err_set_i (bus_err_set),
        .sw_i          (sw),
        .rdata_o       (mmio_rdata),
        .led_o         (led),
        .irq_o         (irq)
    );

    assign readdataM = ram_hit ? ram_q[ram_idx] : mmio_rdata;

endmodule

// File: tb/tb_mips_data_mem.sv
// Directed bench for mips_data_mem: RAM, LED, timer/STATUS, bus errors,
// switch synchronisation and mid-run reset.
module tb_mips_data_mem;

    localparam logic [31:0] A_LED    = 32'h8000_0000;
    localparam logic [31:0] A_SW     = 32'h8000_0004;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0008;
    localparam logic [31:0] A_CMP    = 32'h8000_000C;
    localparam logic [31:0] A_STATUS = 32'h8000_0010;

    logic        clk;
    logic        rst;
    logic        memwriteM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic [15:0] sw;
    logic [15:0] led;
    logic        irq;

    int total;
    int bad;
    logic [31:0] cyc_model;
    logic [31:0] rd;

    mips_data_mem dut (
        .clk        (clk),
        .rst        (rst),
        .memwriteM  (memwriteM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .sw         (sw),
        .led        (led),
        .irq        (irq)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle counter: posedges since the last reset edge.
    always @(posedge clk) begin
        if (rst) cyc_model <= 32'd0;
        else     cyc_model <= cyc_model + 32'd1;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        aluoutM    = addr;
        writedataM = data;
        memwriteM  = 1'b1;
        tick();
        memwriteM  = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
        aluoutM = addr;
        #1;
        data = readdataM;
    endtask

    // Scenarios
    task automatic test_reset();
        do_reset();
        do_read(A_LED, rd);
        total++;
        if (rd !== 32'd0 || led !== 16'd0) begin
            bad++; $display("FAIL reset_led: got %h/%h expected 0", rd, led);
        end
        do_read(A_CMP, rd);
        total++;
        if (rd !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL reset_cmp: got %h expected ffffffff", rd);
        end
        do_read(A_STATUS, rd);
        total++;
        if (rd !== 32'd0 || irq !== 1'b0) begin
            bad++; $display("FAIL reset_status: got %h irq %b expected 0", rd, irq);
        end
        do_read(A_CYCLE, rd);
        total++;
        if (rd !== 32'd0) begin
            bad++; $display("FAIL reset_cycle: got %h expected 0", rd);
        end
    endtask

    task automatic test_ram();
        do_write(32'h0000_0010, 32'hDEAD_BEEF);
        do_read(32'h0000_0010, rd);
        total++;
        if (rd !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL ram_rw: got %h expected deadbeef", rd);
        end
        do_write(32'h0000_03FC, 32'h1357_9BDF);
        do_write(32'h0000_0000, 32'h0246_8ACE);
        do_read(32'h0000_03FC, rd);
        total++;
        if (rd !== 32'h1357_9BDF) begin
            bad++; $display("FAIL ram_top: got %h expected 13579bdf", rd);
        end
        do_read(32'h0000_0000, rd);
        total++;
        if (rd !== 32'h0246_8ACE) begin
            bad++; $display("FAIL ram_bottom: got %h expected 02468ace", rd);
        end
    endtask

    task automatic test_led();
        do_write(A_LED, 32'hFFFF_A5A5);
        total++;
        if (led !== 16'hA5A5) begin
            bad++; $display("FAIL led_out: got %h expected a5a5", led);
        end
        do_read(A_LED, rd);
        total++;
        if (rd !== 32'h0000_A5A5) begin
            bad++; $display("FAIL led_read: got %h expected 0000a5a5", rd);
        end
    endtask

    task automatic test_timer();
        logic [31:0] target;
        do_reset();
        do_write(A_CMP, 32'd5);
        while (cyc_model < 32'd5) tick();
        do_read(A_STATUS, rd);
        total++;
        if (rd !== 32'd0 || irq !== 1'b0) begin
            bad++; $display("FAIL timer_early: got %h irq %b expected 0", rd, irq);
        end
        tick();
        do_read(A_STATUS, rd);
        total++;
        if (rd !== 32'd1 || irq !== 1'b1) begin
            bad++; $display("FAIL timer_hit: got %h irq %b expected 1", rd, irq);
        end
        do_write(A_STATUS, 32'd1);
        do_read(A_STATUS, rd);
        total++;
        if (rd !== 32'd0 || irq !== 1'b0) begin
            bad++; $display("FAIL timer_w1c: got %h irq %b expected 0", rd, irq);
        end
        // W1C issued in the match cycle: set must win.
        target = cyc_model + 32'd4;
        do_write(A_CMP, target);
        while (cyc_model < target) tick();
        do_write(A_STATUS, 32'd1);
        do_read(A_STATUS, rd);
        total++;
        if (rd !== 32'd1) begin
            bad++; $display("FAIL set_wins: got %h expected 1", rd);
        end
        do_write(A_STATUS, 32'd1);
        do_read(32'h4000_0000, rd);
        total++;
        if (rd !== 32'd0) begin
            bad++; $display("FAIL unmapped_read: got %h expected 0", rd);
        end
        tick();
        do_read(A_STATUS, rd);
        total++;
        if (rd !== 32'd0) begin
            bad++; $display("FAIL read_no_err: got %h expected 0", rd);
        end
    endtask

    task automatic test_bus_err();
        do_write(32'h0000_0000, 32'h1111_2222);
        do_write(32'h0000_0002, 32'h3333_4444);
        do_read(32'h0000_0000, rd);
        total++;
        if (rd !== 32'h1111_2222) begin
            bad++; $display("FAIL misaligned_ignored: got %h expected 11112222", rd);
        end
        do_read(32'h0000_0002, rd);
        total++;
        if (rd !== 32'd0) begin
            bad++; $display("FAIL misaligned_read: got %h expected 0", rd);
        end
        do_read(A_STATUS, rd);
        total++;
        if (rd !== 32'h2) begin
            bad++; $display("FAIL bus_err_misaligned: got %h expected 2", rd);
        end
        do_write(A_STATUS, 32'h2);
        do_write(A_CYCLE, 32'd0);
        do_read(A_CYCLE, rd);
        total++;
        if (rd !== cyc_model) begin
            bad++; $display("FAIL cycle_ro: got %h expected %h", rd, cyc_model);
        end
        do_read(A_STATUS, rd);
        total++;
        if (rd !== 32'h2) begin
            bad++; $display("FAIL bus_err_cycle: got %h expected 2", rd);
        end
        do_write(A_STATUS, 32'h2);
        do_write(32'h0000_0400, 32'h5555_6666);
        do_read(A_STATUS, rd);
        total++;
        if (rd !== 32'h2) begin
            bad++; $display("FAIL bus_err_past_ram: got %h expected 2", rd);
        end
        do_read(32'h0000_0000, rd);
        total++;
        if (rd !== 32'h1111_2222) begin
            bad++; $display("FAIL past_ram_no_alias: got %h expected 11112222", rd);
        end
    endtask

    task automatic test_sw_sync();
        sw = 16'h00FF;
        tick(); tick(); tick();
        sw = 16'h1234;
        do_read(A_SW, rd);
        total++;
        if (rd !== 32'h0000_00FF) begin
            bad++; $display("FAIL sw_t0: got %h expected 000000ff", rd);
        end
        tick();
        do_read(A_SW, rd);
        total++;
        if (rd !== 32'h0000_00FF) begin
            bad++; $display("FAIL sw_t1: got %h expected 000000ff", rd);
        end
        tick();
        do_read(A_SW, rd);
        total++;
        if (rd !== 32'h0000_1234) begin
            bad++; $display("FAIL sw_t2: got %h expected 00001234", rd);
        end
    endtask

    task automatic test_mid_reset();
        do_write(32'h0000_0020, 32'hCAFE_F00D);
        do_write(A_LED, 32'h0000_FFFF);
        do_write(32'h0000_0003, 32'd0);
        do_write(A_CMP, 32'h0001_0000);
        repeat (110) tick();
        do_read(A_CYCLE, rd);
        total++;
        if (rd !== cyc_model || rd <= 32'd100) begin
            bad++; $display("FAIL cycle_run: got %h expected %h", rd, cyc_model);
        end
        // RAM store presented during the reset cycle must be dropped.
        rst        = 1'b1;
        aluoutM    = 32'h0000_0020;
        writedataM = 32'h0BAD_0BAD;
        memwriteM  = 1'b1;
        tick();
        rst        = 1'b0;
        memwriteM  = 1'b0;
        total++;
        if (led !== 16'd0) begin
            bad++; $display("FAIL rst_led: got %h expected 0", led);
        end
        do_read(A_CYCLE, rd);
        total++;
        if (rd !== 32'd0) begin
            bad++; $display("FAIL rst_cycle: got %h expected 0", rd);
        end
        do_read(A_STATUS, rd);
        total++;
        if (rd !== 32'd0) begin
            bad++; $display("FAIL rst_status: got %h expected 0", rd);
        end
        do_read(A_CMP, rd);
        total++;
        if (rd !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL rst_cmp: got %h expected ffffffff", rd);
        end
        do_read(32'h0000_0020, rd);
        total++;
        if (rd !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL rst_ram_write: got %h expected cafef00d", rd);
        end
    endtask

    // Sequence and final report
    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        memwriteM  = 1'b0;
        aluoutM    = 32'd0;
        writedataM = 32'd0;
        sw         = 16'd0;
        tick();
        test_reset();
        test_ram();
        test_led();
        test_timer();
        test_bus_err();
        test_sw_sync();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
